// File: rtl/memif_axi_pkg.sv
// rtl/memif_axi_pkg.sv - shared widths, response codes and FSM states for the AXI write arbiter
package memif_axi_pkg;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 8;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-request round-robin picker, combinational one-hot grant
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    // last_grant = 1 means requester 1 was served last, so requester 0 wins a tie
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// rtl/axi_wr_arbiter.sv - two-port AXI write arbiter, whole-transaction grant AW -> W -> B
module axi_wr_arbiter
    import memif_axi_pkg::*;
#(
    parameter int ADDR_W = memif_axi_pkg::ADDR_W,
    parameter int DATA_W = memif_axi_pkg::DATA_W,
    parameter int LEN_W  = memif_axi_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_awvalid,
    output logic              m0_awready,
    input  logic [ADDR_W-1:0] m0_awaddr,
    input  logic [LEN_W-1:0]  m0_awlen,
    input  logic              m0_wvalid,
    output logic              m0_wready,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_wlast,
    output logic              m0_bvalid,
    input  logic              m0_bready,
    output logic [1:0]        m0_bresp,
    input  logic              m1_awvalid,
    output logic              m1_awready,
    input  logic [ADDR_W-1:0] m1_awaddr,
    input  logic [LEN_W-1:0]  m1_awlen,
    input  logic              m1_wvalid,
    output logic              m1_wready,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_wlast,
    output logic              m1_bvalid,
    input  logic              m1_bready,
    output logic [1:0]        m1_bresp,
    output logic              s_awvalid,
    input  logic              s_awready,
    output logic [ADDR_W-1:0] s_awaddr,
    output logic [LEN_W-1:0]  s_awlen,
    output logic              s_wvalid,
    input  logic              s_wready,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_wlast,
    input  logic              s_bvalid,
    output logic              s_bready,
    input  logic [1:0]        s_bresp,
    output logic [1:0]        grant,
    output logic              protocol_err
);

    state_t             state_q, state_d;
    logic [1:0]         grant_q, grant_d;
    logic               last_q, last_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               perr_q, perr_d;
    logic [1:0]         arb_gnt;
    logic               sel;
    logic               in_addr, in_data, in_resp;

    rr_arb2 u_arb (
        .req        ({m1_awvalid, m0_awvalid}),
        .last_grant (last_q),
        .gnt        (arb_gnt)
    );

    assign sel     = grant_q[1];
    assign in_addr = (state_q == ADDR);
    assign in_data = (state_q == DATA);
    assign in_resp = (state_q == RESP);

    // Payloads follow the owner freely; only the valids/readies are state-gated
    assign s_awaddr  = sel ? m1_awaddr : m0_awaddr;
    assign s_awlen   = sel ? m1_awlen  : m0_awlen;
    assign s_wdata   = sel ? m1_wdata  : m0_wdata;
    assign s_wlast   = sel ? m1_wlast  : m0_wlast;
    assign s_awvalid = in_addr & (sel ? m1_awvalid : m0_awvalid);
    assign s_wvalid  = in_data & (sel ? m1_wvalid  : m0_wvalid);
    assign s_bready  = in_resp & (sel ? m1_bready  : m0_bready);

    assign m0_awready = in_addr & grant_q[0] & s_awready;
    assign m0_wready  = in_data & grant_q[0] & s_wready;
    assign m0_bvalid  = in_resp & grant_q[0] & s_bvalid;
    assign m0_bresp   = s_bresp;
    assign m1_awready = in_addr & grant_q[1] & s_awready;
    assign m1_wready  = in_data & grant_q[1] & s_wready;
    assign m1_bvalid  = in_resp & grant_q[1] & s_bvalid;
    assign m1_bresp   = s_bresp;

    assign grant        = grant_q;
    assign protocol_err = perr_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        perr_d  = perr_q;
        case (state_q)
            IDLE: begin
                if (|arb_gnt) begin
                    grant_d = arb_gnt;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (s_awvalid && s_awready) begin
                    cnt_d   = sel ? m1_awlen : m0_awlen;
                    state_d = DATA;
                end
            end
            DATA: begin
                // wlast alone ends the burst; the count only judges whether it came on time
                if (s_wvalid && s_wready) begin
                    if (s_wlast != (cnt_q == '0)) perr_d = 1'b1;
                    if (cnt_q != '0) cnt_d = cnt_q - LEN_W'(1);
                    if (s_wlast) state_d = RESP;
                end
            end
            RESP: begin
                if (s_bvalid && s_bready) begin
                    state_d = IDLE;
                    last_d  = grant_q[1];
                    grant_d = 2'b00;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            perr_q  <= perr_d;
        end
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb/tb_axi_wr_arbiter.sv - directed table-driven bench for axi_wr_arbiter
module tb_axi_wr_arbiter;
    import memif_axi_pkg::*;

    localparam logic [24:0] ADDR0 = 25'h000100;
    localparam logic [24:0] ADDR1 = 25'h000200;
    localparam logic [15:0] BASE0 = 16'h1111;
    localparam logic [15:0] BASE1 = 16'h2221;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_wlast, m0_bvalid, m0_bready;
    logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_wlast, m1_bvalid, m1_bready;
    logic [24:0] m0_awaddr, m1_awaddr, s_awaddr;
    logic [7:0]  m0_awlen, m1_awlen, s_awlen;
    logic [15:0] m0_wdata, m1_wdata, s_wdata;
    logic [1:0]  m0_bresp, m1_bresp, s_bresp, grant;
    logic s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready, protocol_err;

    always #5 clk = ~clk;

    axi_wr_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_awvalid(m0_awvalid), .m0_awready(m0_awready), .m0_awaddr(m0_awaddr), .m0_awlen(m0_awlen),
        .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_wdata(m0_wdata), .m0_wlast(m0_wlast),
        .m0_bvalid(m0_bvalid), .m0_bready(m0_bready), .m0_bresp(m0_bresp),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wlast(m1_wlast),
        .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .grant(grant), .protocol_err(protocol_err)
    );

    typedef struct {
        int         n0, n1;
        logic [7:0] len0, len1;
        int         last0, last1;
        bit         wtoggle;
        int         bdelay;
        logic [1:0] bresp;
        logic [7:0] order;
        int         ntxn;
        bit         perr;
        bit         do_reset;
    } row_t;

    row_t rows[8];
    row_t mid_row;

    int n_checks = 0;
    int n_fail   = 0;

    bit         act[2];
    bit         awd[2];
    int         left[2];
    int         beat[2];
    logic [7:0] len[2];
    int         lastp[2];

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act_v, exp_v);
        end
    endtask

    task automatic drive_inputs();
        m0_awvalid = act[0] && !awd[0];
        m0_awaddr  = ADDR0;
        m0_awlen   = len[0];
        m0_wvalid  = act[0] && (beat[0] <= lastp[0]);
        m0_wdata   = BASE0 + 16'(beat[0]);
        m0_wlast   = act[0] && (beat[0] == lastp[0]);
        m0_bready  = act[0] && awd[0] && (beat[0] > lastp[0]);
        m1_awvalid = act[1] && !awd[1];
        m1_awaddr  = ADDR1;
        m1_awlen   = len[1];
        m1_wvalid  = act[1] && (beat[1] <= lastp[1]);
        m1_wdata   = BASE1 + 16'(beat[1]);
        m1_wlast   = act[1] && (beat[1] == lastp[1]);
        m1_bready  = act[1] && awd[1] && (beat[1] > lastp[1]);
    endtask

    task automatic run_row(input row_t r, input int stop_beats);
        int issued, done, beats, cyc, sl_beat, owner, bwait;
        bit bpend, blk;
        bit hs_aw[2], hs_w[2], hs_b[2];
        issued = 0; done = 0; beats = 0; cyc = 0; sl_beat = 0; owner = 0; bwait = 0;
        bpend = 0; blk = 0;
        act[0] = 0; act[1] = 0;
        s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b0; s_bresp = r.bresp;
        if (r.do_reset) begin
            drive_inputs();
            reset = 1'b1;
            repeat (2) @(posedge clk);
            #1;
        end
        reset = 1'b0;
        act[0] = (r.n0 > 0); left[0] = r.n0; awd[0] = 0; beat[0] = 0; len[0] = r.len0; lastp[0] = r.last0;
        act[1] = (r.n1 > 0); left[1] = r.n1; awd[1] = 0; beat[1] = 0; len[1] = r.len1; lastp[1] = r.last1;
        drive_inputs();
        while (done < r.ntxn && cyc < 2000 && !(stop_beats > 0 && beats >= stop_beats)) begin
            @(negedge clk);
            cyc++;
            hs_aw[0] = m0_awvalid && m0_awready; hs_aw[1] = m1_awvalid && m1_awready;
            hs_w[0]  = m0_wvalid && m0_wready;   hs_w[1]  = m1_wvalid && m1_wready;
            hs_b[0]  = m0_bvalid && m0_bready;   hs_b[1]  = m1_bvalid && m1_bready;
            if (!grant[0] && (m0_awready || m0_wready || m0_bvalid)) blk = 1;
            if (!grant[1] && (m1_awready || m1_wready || m1_bvalid)) blk = 1;
            if (bpend && s_awvalid) blk = 1;
            if (s_awvalid && s_awready) begin
                owner = int'(r.order[issued]);
                issued++;
                sl_beat = 0;
                check("aw_grant", 32'(grant), (owner == 1) ? 32'h2 : 32'h1);
                check("aw_addr", 32'(s_awaddr), (owner == 1) ? 32'(ADDR1) : 32'(ADDR0));
                check("aw_len", 32'(s_awlen), (owner == 1) ? 32'(r.len1) : 32'(r.len0));
            end
            if (s_wvalid && s_wready) begin
                check("w_data", 32'(s_wdata), 32'(((owner == 1) ? BASE1 : BASE0) + 16'(sl_beat)));
                check("w_last", 32'(s_wlast), 32'(sl_beat == ((owner == 1) ? r.last1 : r.last0)));
                beats++;
                sl_beat++;
                if (s_wlast) begin
                    bpend = 1;
                    bwait = r.bdelay;
                end
            end
            if (s_bvalid && s_bready) begin
                check("b_owner", 32'({m1_bvalid, m0_bvalid}), (owner == 1) ? 32'h2 : 32'h1);
                check("b_resp", 32'((owner == 1) ? m1_bresp : m0_bresp), 32'(r.bresp));
                bpend = 0;
                done++;
            end
            if (stop_beats > 0 && beats >= stop_beats) break;
            @(posedge clk);
            #1;
            for (int n = 0; n < 2; n++) begin
                if (hs_aw[n]) awd[n] = 1;
                if (hs_w[n]) beat[n]++;
                if (hs_b[n]) begin
                    left[n]--;
                    awd[n] = 0;
                    beat[n] = 0;
                    if (left[n] == 0) act[n] = 0;
                end
            end
            s_wready = r.wtoggle ? ~s_wready : 1'b1;
            if (bpend && bwait > 0) bwait--;
            s_bvalid = bpend && (bwait == 0);
            drive_inputs();
        end
        if (stop_beats == 0) begin
            check("txn_done", 32'(done), 32'(r.ntxn));
            check("beat_total", 32'(beats), 32'(r.n0 * (r.last0 + 1) + r.n1 * (r.last1 + 1)));
            check("blocking", 32'(blk), 32'h0);
            @(negedge clk);
            check("end_grant", 32'(grant), 32'h0);
            check("end_perr", 32'(protocol_err), 32'(r.perr));
        end
    endtask

    initial begin
        //          n0 n1 len0   len1   l0 l1 tog bdly bresp   order        ntxn perr rst
        rows[0] = '{1, 0, 8'd3,  8'd0,  3, 0, 0,  0,   OKAY,   8'b0,        1,   0,   1};
        rows[1] = '{1, 1, 8'd7,  8'd7,  7, 7, 0,  0,   OKAY,   8'b10,       2,   0,   1};
        rows[2] = '{3, 3, 8'd1,  8'd1,  1, 1, 0,  0,   OKAY,   8'b101010,   6,   0,   1};
        rows[3] = '{0, 1, 8'd0,  8'd15, 0, 15, 1, 10,  SLVERR, 8'b1,        1,   0,   1};
        rows[4] = '{0, 1, 8'd0,  8'd0,  0, 0, 0,  0,   OKAY,   8'b1,        1,   0,   1};
        rows[5] = '{1, 0, 8'd3,  8'd0,  1, 0, 0,  2,   OKAY,   8'b0,        1,   1,   1};
        rows[6] = '{0, 1, 8'd0,  8'd0,  0, 0, 0,  0,   OKAY,   8'b1,        1,   1,   0};
        rows[7] = '{1, 0, 8'd1,  8'd0,  2, 0, 0,  0,   OKAY,   8'b0,        1,   1,   1};
        mid_row = '{1, 0, 8'd7,  8'd0,  7, 0, 0,  0,   OKAY,   8'b0,        1,   0,   1};

        act[0] = 0; act[1] = 0; awd[0] = 0; awd[1] = 0; beat[0] = 0; beat[1] = 0;
        len[0] = 0; len[1] = 0; lastp[0] = 0; lastp[1] = 0; left[0] = 0; left[1] = 0;
        drive_inputs();
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = OKAY;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_state",
              32'({grant, protocol_err, s_awvalid, s_wvalid, s_bready,
                   m0_awready, m0_wready, m0_bvalid, m1_awready, m1_wready, m1_bvalid}), 32'h0);

        // Grant latency and grant stability when the owner withdraws
        @(posedge clk);
        #1;
        m0_awvalid = 1'b1;
        @(negedge clk);
        check("lat_t_awvalid", 32'(s_awvalid), 32'h0);
        @(negedge clk);
        check("lat_t1_awvalid", 32'(s_awvalid), 32'h1);
        check("lat_t1_grant", 32'(grant), 32'h1);
        @(posedge clk);
        #1;
        m0_awvalid = 1'b0;
        m1_awvalid = 1'b1;
        repeat (2) @(negedge clk);
        check("hold_grant", 32'(grant), 32'h1);
        check("hold_awvalid", 32'(s_awvalid), 32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_row(rows[i], 0);
        end

        // Reset after beat 2 of 8, then a fresh tie must go to m0
        run_row(mid_row, 2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        act[0] = 0; act[1] = 0;
        drive_inputs();
        s_bvalid = 1'b0;
        @(negedge clk);
        check("midrst_outputs",
              32'({grant, s_awvalid, s_wvalid, s_bready, m0_awready, m0_wready, m0_bvalid,
                   m1_awready, m1_wready, m1_bvalid}), 32'h0);
        rows[1].do_reset = 0;
        run_row(rows[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
